instruction_memory_sync: RTL and testbench

INSTRUCTION_MEMORY_SYNC -- requirements
Module: instruction_memory_sync

---
 rtl/instruction_memory_sync.sv | 138 +++++++++++++
 tb/tb_instruction_memory_sync.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_sync.sv
// Byte-addressed instruction memory: byte-wide program loading, 4-byte fetch
// with a one-entry registered response, and alignment/range fault reporting.
module instruction_memory_sync #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter bit BIG_ENDIAN  = 1'b1,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instruction,
    output logic              instr_fault,
    output logic [1:0]        fault_code,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              load_err
);
    localparam int                IDX_W         = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_WORD     = ADDR_W'(DEPTH - 32'd4);
    localparam logic [ADDR_W-1:0] MEM_SIZE      = ADDR_W'(DEPTH);
    localparam logic [1:0]        CODE_NONE     = 2'b00;
    localparam logic [1:0]        CODE_MISALIGN = 2'b01;
    localparam logic [1:0]        CODE_RANGE    = 2'b10;

    typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [7:0]       mem_q [DEPTH];
    logic [31:0]      instr_q, instr_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;
    logic             load_err_q, load_err_d;

    logic             misalign_s;
    logic             out_of_range_s;
    logic             load_ok_s;
    logic             accept_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      word_s;

    function automatic logic [31:0] pack_word(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input logic [7:0] b3);
        if (BIG_ENDIAN) begin
            return {b0, b1, b2, b3};
        end else begin
            return {b3, b2, b1, b0};
        end
    endfunction

    // Range checks use the full address width so high addresses never alias into memory.
    assign misalign_s     = CHECK_ALIGN && (fetch_addr[1:0] != 2'b00);
    assign out_of_range_s = fetch_addr > LAST_WORD;
    assign load_ok_s      = load_addr < MEM_SIZE;

    assign instr_valid = (state_q == ST_RESP);
    assign fetch_ready = rst_n && !load_en && !(instr_valid && !instr_ready);
    assign accept_s    = fetch_req && fetch_ready;

    assign idx_s  = fetch_addr[IDX_W-1:0];
    assign word_s = pack_word(mem_q[idx_s], mem_q[idx_s + IDX_W'(32'd1)],
                              mem_q[idx_s + IDX_W'(32'd2)], mem_q[idx_s + IDX_W'(32'd3)]);

    // Program-load write port; storage is deliberately kept out of reset.
    always_ff @(posedge clk) begin
        if (load_en && load_ok_s) begin
            mem_q[load_addr[IDX_W-1:0]] <= load_data;
        end
    end

    // Response FSM next state and response payload capture.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        fault_d    = fault_q;
        code_d     = code_q;
        load_err_d = load_en && !load_ok_s;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_RESP;
                else          state_d = ST_IDLE;
            end
            ST_RESP: begin
                if (accept_s)         state_d = ST_RESP;
                else if (instr_ready) state_d = ST_IDLE;
                else                  state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept_s) begin
            if (misalign_s) begin
                fault_d = 1'b1;
                code_d  = CODE_MISALIGN;
                instr_d = 32'h0000_0000;
            end else if (out_of_range_s) begin
                fault_d = 1'b1;
                code_d  = CODE_RANGE;
                instr_d = 32'h0000_0000;
            end else begin
                fault_d = 1'b0;
                code_d  = CODE_NONE;
                instr_d = word_s;
            end
        end else begin
            instr_d = instr_q;
            fault_d = fault_q;
            code_d  = code_q;
        end
    end

    // State and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            instr_q    <= 32'h0000_0000;
            fault_q    <= 1'b0;
            code_q     <= CODE_NONE;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            fault_q    <= fault_d;
            code_q     <= code_d;
            load_err_q <= load_err_d;
        end
    end

    assign instruction = instr_q;
    assign instr_fault = fault_q;
    assign fault_code  = code_q;
    assign load_err    = load_err_q;

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Directed + randomized bench for instruction_memory_sync; two instances share
// stimulus: big-endian with alignment check, little-endian without it.
`timescale 1ns/1ps
module tb_instruction_memory_sync;
    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        instr_ready;
    logic        load_en;
    logic [31:0] load_addr;
    logic [7:0]  load_data;

    logic        fetch_ready,    fetch_ready_le;
    logic        instr_valid,    instr_valid_le;
    logic [31:0] instruction,    instruction_le;
    logic        instr_fault,    instr_fault_le;
    logic [1:0]  fault_code,     fault_code_le;
    logic        load_err,       load_err_le;

    int checks = 0;
    int errors = 0;
    logic [7:0] ref_mem [256];

    instruction_memory_sync #(.DEPTH(256), .ADDR_W(32), .BIG_ENDIAN(1'b1), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_fault(instr_fault), .fault_code(fault_code),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_err(load_err));

    instruction_memory_sync #(.DEPTH(256), .ADDR_W(32), .BIG_ENDIAN(1'b0), .CHECK_ALIGN(1'b0)) dut_le (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready_le), .instr_valid(instr_valid_le), .instr_ready(instr_ready),
        .instruction(instruction_le), .instr_fault(instr_fault_le), .fault_code(fault_code_le),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_err(load_err_le));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {fault, code, word} from the byte array and the addressing rules.
    function automatic logic [34:0] model(input logic [31:0] a, input bit be, input bit ca);
        logic [1:0]  c;
        logic [31:0] w;
        c = 2'b00;
        w = 32'h0;
        if (ca && (a % 32'd4) != 32'd0)  c = 2'b01;
        else if (a > 32'd252)            c = 2'b10;
        else if (be) w = {ref_mem[a], ref_mem[a+32'd1], ref_mem[a+32'd2], ref_mem[a+32'd3]};
        else         w = {ref_mem[a+32'd3], ref_mem[a+32'd2], ref_mem[a+32'd1], ref_mem[a]};
        return {(c != 2'b00), c, w};
    endfunction

    task automatic chk_resp(input string tag, input logic [31:0] a);
        logic [34:0] eb, el;
        eb = model(a, 1'b1, 1'b1);
        el = model(a, 1'b0, 1'b0);
        chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
        chk({tag, ".instr"}, instruction, eb[31:0]);
        chk({tag, ".fault"}, 32'(instr_fault), 32'(eb[34]));
        chk({tag, ".code"},  32'(fault_code), 32'(eb[33:32]));
        chk({tag, ".le_valid"}, 32'(instr_valid_le), 32'd1);
        chk({tag, ".le_instr"}, instruction_le, el[31:0]);
        chk({tag, ".le_fault"}, 32'(instr_fault_le), 32'(el[34]));
        chk({tag, ".le_code"},  32'(fault_code_le), 32'(el[33:32]));
    endtask

    task automatic load_byte(input logic [31:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
        if (a < 32'd256) ref_mem[a] = d;
        chk("load_err", 32'(load_err), 32'(a >= 32'd256));
        chk("load_err_le", 32'(load_err_le), 32'(a >= 32'd256));
    endtask

    task automatic fetch_one(input string tag, input logic [31:0] a, input int stall);
        fetch_req = 1'b1; fetch_addr = a; instr_ready = 1'b1;
        #1;
        chk({tag, ".ready"}, 32'(fetch_ready), 32'd1);
        @(posedge clk); #1;
        fetch_req = 1'b0;
        instr_ready = (stall == 0);
        #1;
        chk_resp(tag, a);
        for (int k = 0; k < stall; k++) begin
            chk({tag, ".stall_ready"}, 32'(fetch_ready), 32'd0);
            @(posedge clk); #1;
            chk_resp({tag, ".held"}, a);
        end
        instr_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".drain"}, 32'(instr_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        rst_n = 1'b0; fetch_req = 1'b1; fetch_addr = 32'd0; instr_ready = 1'b1;
        load_en = 1'b0; load_addr = 32'd0; load_data = 8'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(instr_valid), 32'd0);
        chk("rst.instr", instruction, 32'd0);
        chk("rst.fault", 32'(instr_fault), 32'd0);
        chk("rst.code", 32'(fault_code), 32'd0);
        chk("rst.load_err", 32'(load_err), 32'd0);
        chk("rst.fetch_ready", 32'(fetch_ready), 32'd0);
        fetch_req = 1'b0;
        rst_n = 1'b1;

        // Preload every byte; bytes 20..23 hold 00 00 00 06
        for (int i = 0; i < 256; i++) begin
            if (i >= 20 && i <= 23) load_byte(32'(i), (i == 23) ? 8'h06 : 8'h00);
            else                    load_byte(32'(i), 8'($urandom));
        end

        fetch_req = 1'b1; fetch_addr = 32'd20; instr_ready = 1'b1;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        chk("f20.be", instruction, 32'h0000_0006);
        chk("f20.le", instruction_le, 32'h0600_0000);
        chk_resp("f20", 32'd20);
        @(posedge clk); #1;

        // Fault cases, including a high address that must not wrap
        fetch_one("f21", 32'd21, 0);
        fetch_one("f253", 32'd253, 0);
        fetch_one("f256", 32'd256, 0);
        fetch_one("f252", 32'd252, 0);
        fetch_one("fhigh", 32'hFFFF_FFFC, 1);
        fetch_one("f255", 32'd255, 2);

        // Back-pressure for 3 cycles, then same-cycle acceptance on release
        fetch_req = 1'b1; fetch_addr = 32'd24; instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0; fetch_addr = 32'd28;
        #1;
        chk_resp("stall", 32'd24);
        for (int k = 0; k < 3; k++) begin
            chk("stall.ready", 32'(fetch_ready), 32'd0);
            @(posedge clk); #1;
            chk_resp("stall.held", 32'd24);
        end
        instr_ready = 1'b1;
        #1;
        chk("release.ready", 32'(fetch_ready), 32'd1);
        @(posedge clk); #1;
        fetch_req = 1'b0;
        chk_resp("release", 32'd28);
        @(posedge clk); #1;
        chk("release.drain", 32'(instr_valid), 32'd0);

        // Back-to-back 0, 4, 8 with no bubbles
        fetch_req = 1'b1; fetch_addr = 32'd0;
        @(posedge clk); #1;
        chk_resp("b2b0", 32'd0);
        fetch_addr = 32'd4;
        #1;
        chk("b2b.ready", 32'(fetch_ready), 32'd1);
        @(posedge clk); #1;
        chk_resp("b2b4", 32'd4);
        fetch_addr = 32'd8;
        @(posedge clk); #1;
        chk_resp("b2b8", 32'd8);
        fetch_req = 1'b0;
        @(posedge clk); #1;
        chk("b2b.drain", 32'(instr_valid), 32'd0);

        // Dropped load blocks a simultaneous fetch and pulses load_err once
        load_en = 1'b1; load_addr = 32'd300; load_data = 8'hA5;
        fetch_req = 1'b1; fetch_addr = 32'd0;
        #1;
        chk("ldrop.ready", 32'(fetch_ready), 32'd0);
        @(posedge clk); #1;
        load_en = 1'b0; fetch_req = 1'b0;
        chk("ldrop.err", 32'(load_err), 32'd1);
        chk("ldrop.noaccept", 32'(instr_valid), 32'd0);
        @(posedge clk); #1;
        chk("ldrop.err_end", 32'(load_err), 32'd0);
        fetch_one("ldrop.mem44", 32'd44, 0);

        // Load followed immediately by a fetch of the same word
        load_byte(32'd40, 8'h5C);
        fetch_one("ldfetch", 32'd40, 0);

        // Randomized mix of loads and fetches against the reference model
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = 32'($urandom_range(0, 299));
                if (a >= 32'd20 && a <= 32'd23) a = a + 32'd8;
                load_byte(a, 8'($urandom));
            end else begin
                case ($urandom_range(0, 3))
                    0:       a = 32'($urandom_range(0, 63)) * 32'd4;
                    1:       a = 32'($urandom_range(0, 260));
                    2:       a = 32'($urandom_range(248, 270));
                    default: a = $urandom;
                endcase
                fetch_one("rand", a, int'($urandom_range(0, 2)));
            end
        end

        // Reset during a pending response discards it but keeps memory
        fetch_req = 1'b1; fetch_addr = 32'd20; instr_ready = 1'b0;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        chk("rstmid.pending", 32'(instr_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid.ready", 32'(fetch_ready), 32'd0);
        @(posedge clk); #1;
        chk("rstmid.valid", 32'(instr_valid), 32'd0);
        chk("rstmid.instr", instruction, 32'd0);
        chk("rstmid.code", 32'(fault_code), 32'd0);
        rst_n = 1'b1; instr_ready = 1'b1;
        fetch_req = 1'b1; fetch_addr = 32'd20;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        chk("rstmid.f20", instruction, 32'h0000_0006);
        chk_resp("rstmid.f20", 32'd20);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
